// File: rtl/gpr_mp_pkg.sv
// Shared constants for the NPC register file and hazard logic.
// addr_w() derives the per-port address width used to slice flat address buses.
package gpr_mp_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    function automatic int addr_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared by writeback.
// A same-cycle alloc beats a clear because the newer producer supersedes the older one.
module gpr_scoreboard
    import gpr_mp_pkg::*;
#(
    parameter int NREG = gpr_mp_pkg::NREG,
    parameter int NWR  = 1,
    parameter int AW   = addr_w(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr;

    always_comb begin
        clr    = '0;
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w]) begin
                clr[wr_addr_i[w*AW +: AW]] = 1'b1;
            end
        end
        for (int r = 1; r < NREG; r++) begin
            if (alloc_en_i && (alloc_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        // x0 never has a pending producer
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file with x0 hardwired to zero,
// optional write-to-read bypass and an integrated pending-write scoreboard.
module gpr_mp
    import gpr_mp_pkg::*;
#(
    parameter int XLEN   = gpr_mp_pkg::XLEN,
    parameter int NREG   = gpr_mp_pkg::NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*addr_w(NREG)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]         rd_data_o,
    output logic [NRD-1:0]              rd_busy_o,
    input  logic [NWR-1:0]              wr_en_i,
    input  logic [NWR*addr_w(NREG)-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0]         wr_data_i,
    input  logic                        alloc_en_i,
    input  logic [addr_w(NREG)-1:0]     alloc_addr_i,
    output logic [NREG-1:0]             busy_vec_o
);

    localparam int AW = addr_w(NREG);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;

    gpr_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .busy_o       (busy_q)
    );

    // Ascending port order: the last assignment, from the highest port, wins a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                    rf_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            hit;

        assign ra = rd_addr_i[p*AW +: AW];

        always_comb begin
            rdat = rf_q[ra];
            hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
                        rdat = wr_data_i[w*XLEN +: XLEN];
                        hit  = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rdat = '0;
            end
        end

        assign rd_data_o[p*XLEN +: XLEN] = rdat;
        assign rd_busy_o[p]              = busy_q[ra] & ~hit;
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a bypassing and a non-bypassing instance (both two write ports)
// share stimulus and are checked every cycle against one behavioural register-file model.
module tb_gpr_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;

    logic [63:0] rdb_data, rdn_data;
    logic [1:0]  rdb_busy, rdn_busy;
    logic [31:0] bvb, bvn;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    gpr_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rdb_data), .rd_busy_o(rdb_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(bvb)
    );

    gpr_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rdn_data), .rd_busy_o(rdn_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(bvn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file semantics: later ports overwrite earlier ones, x0 stays zero,
    // writes clear busy, an alloc in the same cycle sets it again.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[r]   = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) begin
                    m_rf[wr_addr[w*5 +: 5]]   = wr_data[w*32 +: 32];
                    m_busy[wr_addr[w*5 +: 5]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
        end
    end

    function automatic void exp_rd(input logic [4:0] a, input bit byp,
                                   output logic [31:0] d, output logic b);
        d = m_rf[a];
        b = m_busy[a];
        if (byp) begin
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w] && wr_addr[w*5 +: 5] == a) begin
                    d = wr_data[w*32 +: 32];
                    b = 1'b0;
                end
            end
        end
        if (a == 5'd0) begin
            d = 32'h0;
            b = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] ed;
            logic        eb;
            logic [31:0] ev;
            for (int p = 0; p < 2; p++) begin
                exp_rd(rd_addr[p*5 +: 5], 1'b1, ed, eb);
                chk($sformatf("byp_data%0d", p), 64'(rdb_data[p*32 +: 32]), 64'(ed));
                chk($sformatf("byp_busy%0d", p), 64'(rdb_busy[p]), 64'(eb));
                exp_rd(rd_addr[p*5 +: 5], 1'b0, ed, eb);
                chk($sformatf("nob_data%0d", p), 64'(rdn_data[p*32 +: 32]), 64'(ed));
                chk($sformatf("nob_busy%0d", p), 64'(rdn_busy[p]), 64'(eb));
            end
            for (int r = 0; r < 32; r++) ev[r] = m_busy[r];
            chk("byp_busy_vec", 64'(bvb), 64'(ev));
            chk("nob_busy_vec", 64'(bvn), 64'(ev));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 2'b00;
        wr_addr    = 10'h0;
        wr_data    = 64'h0;
        alloc_en   = 1'b0;
        alloc_addr = 5'd0;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst        = 1'b1;
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        wr_en      = 2'b11;
        wr_addr    = {5'd6, 5'd5};
        wr_data    = {32'h2, 32'h1};
        rd_addr    = 10'h0;
        step();
        chk_on = 1'b1;
        #2 chk("rst_held_busy_vec", 64'(bvb), 64'h0);
        step();
        rst = 1'b0;
        idle();
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #2;
            chk($sformatf("rst_rf%0d", a), 64'(rdb_data), 64'h0);
            chk("rst_bv", 64'(bvn), 64'h0);
            step();
        end

        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        step();
        idle();
        rd_addr = {5'd5, 5'd0};
        #2 chk("wr_rd_p1_byp", 64'(rdb_data[63:32]), 64'hDEADBEEF);
        chk("wr_rd_p1_nob", 64'(rdn_data[63:32]), 64'hDEADBEEF);
        step();

        wr_en = 2'b01; wr_addr = 10'h0; wr_data = {32'h0, 32'h1234};
        rd_addr = 10'h0;
        #2 chk("x0_same_cycle", 64'(rdb_data[31:0]), 64'h0);
        step();
        idle();
        #2 chk("x0_after", 64'(rdn_data[31:0]), 64'h0);
        step();

        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
        rd_addr = {5'd0, 5'd7};
        #2 chk("bypass_on", 64'(rdb_data[31:0]), 64'hA5A5A5A5);
        chk("bypass_off", 64'(rdn_data[31:0]), 64'h0);
        step();
        idle();
        #2 chk("bypass_off_next", 64'(rdn_data[31:0]), 64'hA5A5A5A5);
        step();

        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
        rd_addr = {5'd3, 5'd3};
        #2 chk("conflict_byp", 64'(rdb_data[31:0]), 64'h22);
        step();
        idle();
        #2 chk("conflict_rf", 64'(rdn_data[63:32]), 64'h22);
        step();

        alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr = {5'd9, 5'd9};
        #2 chk("alloc_no_fwd", 64'(rdb_busy), 64'h0);
        step();
        idle();
        #2 chk("alloc_bv9", 64'(bvb[9]), 64'h1);
        chk("alloc_rd_busy", 64'(rdb_busy), 64'h3);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        #2 chk("clr_byp_busy", 64'(rdb_busy[0]), 64'h0);
        chk("clr_nob_busy", 64'(rdn_busy[0]), 64'h1);
        chk("clr_bv_same", 64'(bvb[9]), 64'h1);
        step();
        idle();
        #2 chk("clr_bv_next", 64'(bvb[9]), 64'h0);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
        step();
        idle();
        #2 chk("alloc_wins", 64'(bvb[9]), 64'h1);
        chk("alloc_wins_data", 64'(rdn_data[31:0]), 64'h77);

        alloc_en = 1'b1; alloc_addr = 5'd11;
        step();
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
        step();
        idle();
        rd_addr = {5'd4, 5'd4};
        #2 chk("pre_rst_bv", 64'(bvb), 64'h0A00);
        chk("pre_rst_rf4", 64'(rdn_data[31:0]), 64'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2 chk("post_rst_bv", 64'(bvb), 64'h0);
        chk("post_rst_rf4", 64'(rdn_data[31:0]), 64'h0);
        step();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            wr_en      = 2'($urandom);
            wr_addr    = {raddr(), raddr()};
            wr_data    = {$urandom, $urandom};
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = ($urandom_range(0, 2) == 0) ? wr_addr[4:0] : raddr();
            rd_addr[4:0] = ($urandom_range(0, 1) == 0) ? wr_addr[4:0] : raddr();
            rd_addr[9:5] = ($urandom_range(0, 1) == 0) ? wr_addr[9:5] : raddr();
            step();
        end

        rst = 1'b0;
        idle();
        step();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
